// File: rtl/unidade_load_store_pkg.sv
// ============================================================================
// Module  : unidade_load_store_pkg
// Brief   : Opcodes, FSM state encoding and default widths for the LSU.
// Revision: 1.0
// ============================================================================
`default_nettype none

package unidade_load_store_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 4;
    localparam int DEF_TAG_W   = 3;
    localparam int DEF_QDEPTH  = 2;
    localparam int DEF_MEM_LAT = 2;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_BCAST = 2'd3
    } lsu_state_e;

    function automatic logic is_mem_op(input logic [2:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

`default_nettype wire

// File: rtl/unidade_load_store_memoria.sv
// ============================================================================
// Module  : memoria_dados_param
// Brief   : Private data memory: synchronous write, MEM_LAT-stage read pipe.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memoria_dados_param #(
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q  [DEPTH];
    logic [DATA_W-1:0] mem_d  [DEPTH];
    logic [DATA_W-1:0] pipe_q [MEM_LAT];
    logic [DATA_W-1:0] pipe_d [MEM_LAT];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
        // Stage 0 captures the pre-write contents; the last stage feeds rd_data.
        pipe_d[0] = mem_q[rd_addr];
        for (int k = 1; k < MEM_LAT; k++) begin
            pipe_d[k] = pipe_q[k-1];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int k = 0; k < MEM_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            mem_q  <= mem_d;
            pipe_q <= pipe_d;
        end
    end

    assign rd_data = pipe_q[MEM_LAT-1];

endmodule

`default_nettype wire

// File: rtl/unidade_load_store.sv
// ============================================================================
// Module  : unidade_load_store
// Brief   : In-order load/store unit with request queue and CDB handshake.
//           Define LSU_STORE_ACK_EN to make stores broadcast a CDB ack.
// Revision: 1.0
// ============================================================================
`default_nettype none

module unidade_load_store
    import unidade_load_store_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int QDEPTH  = DEF_QDEPTH,
    parameter int MEM_LAT = DEF_MEM_LAT
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              Issue_valid,
    output logic              Issue_ready,
    input  logic [2:0]        Issue_op,
    input  logic [TAG_W-1:0]  Issue_tag,
    input  logic [DATA_W-1:0] Op1,
    input  logic [DATA_W-1:0] Op2,
    input  logic [DATA_W-1:0] Op3,
    output logic              CDB_req,
    input  logic              CDB_grant,
    output logic [TAG_W-1:0]  CDB_tag,
    output logic [DATA_W-1:0] CDB_data,
    output logic              Busy
);

    localparam int              PTR_W   = $clog2(QDEPTH);
    localparam int              CNT_W   = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [PTR_W:0]  Q_FULL  = (PTR_W+1)'(QDEPTH);
    localparam logic [PTR_W:0]  Q_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] P_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] W_LAST = CNT_W'(MEM_LAT - 1);

    lsu_state_e state_q, state_d;

    logic              q_store_q [QDEPTH], q_store_d [QDEPTH];
    logic [TAG_W-1:0]  q_tag_q   [QDEPTH], q_tag_d   [QDEPTH];
    logic [ADDR_W-1:0] q_addr_q  [QDEPTH], q_addr_d  [QDEPTH];
    logic [DATA_W-1:0] q_data_q  [QDEPTH], q_data_d  [QDEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;

    logic              cur_store_q, cur_store_d;
    logic [TAG_W-1:0]  cur_tag_q, cur_tag_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0] cur_data_q, cur_data_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic              push, pop, q_empty, mem_wr_en;
    logic [DATA_W-1:0] addr_sum, mem_rd_data;

    assign addr_sum = Op1 + Op2;

    generate
        if (DATA_W > ADDR_W) begin : g_unused_sum
            logic unused_sum_bits;
            assign unused_sum_bits = ^addr_sum[DATA_W-1:ADDR_W];
        end
    endgenerate

    assign q_empty     = (count_q == '0);
    assign Issue_ready = (count_q != Q_FULL);
    // NOP and unknown opcodes are handshaken but never enter the queue.
    assign push        = Issue_valid && Issue_ready && !Flush && is_mem_op(Issue_op);

    always_comb begin
        state_d     = state_q;
        cur_store_d = cur_store_q;
        cur_tag_d   = cur_tag_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        result_d    = result_q;
        wait_cnt_d  = wait_cnt_q;
        pop         = 1'b0;
        mem_wr_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    pop         = 1'b1;
                    cur_store_d = q_store_q[rd_ptr_q];
                    cur_tag_d   = q_tag_q[rd_ptr_q];
                    cur_addr_d  = q_addr_q[rd_ptr_q];
                    cur_data_d  = q_data_q[rd_ptr_q];
                    state_d     = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cur_store_q) begin
                    mem_wr_en = 1'b1;
`ifdef LSU_STORE_ACK_EN
                    result_d  = '0;
                    state_d   = ST_BCAST;
`else
                    state_d   = ST_IDLE;
`endif
                end else begin
                    wait_cnt_d = '0;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == W_LAST) begin
                    result_d = mem_rd_data;
                    state_d  = ST_BCAST;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_BCAST: begin
                if (CDB_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (Flush) begin
            state_d   = ST_IDLE;
            pop       = 1'b0;
            mem_wr_en = 1'b0;
        end
    end

    always_comb begin
        q_store_d = q_store_q;
        q_tag_d   = q_tag_q;
        q_addr_d  = q_addr_q;
        q_data_d  = q_data_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (push) begin
            q_store_d[wr_ptr_q] = (Issue_op == OP_STORE);
            q_tag_d[wr_ptr_q]   = Issue_tag;
            q_addr_d[wr_ptr_q]  = addr_sum[ADDR_W-1:0];
            q_data_d[wr_ptr_q]  = Op3;
            wr_ptr_d            = wr_ptr_q + P_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + P_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + Q_ONE;
        end else if (pop && !push) begin
            count_d = count_q - Q_ONE;
        end
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cur_store_q <= 1'b0;
            cur_tag_q   <= '0;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            result_q    <= '0;
            wait_cnt_q  <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_store_q[i] <= 1'b0;
                q_tag_q[i]   <= '0;
                q_addr_q[i]  <= '0;
                q_data_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cur_store_q <= cur_store_d;
            cur_tag_q   <= cur_tag_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            result_q    <= result_d;
            wait_cnt_q  <= wait_cnt_d;
            q_store_q   <= q_store_d;
            q_tag_q     <= q_tag_d;
            q_addr_q    <= q_addr_d;
            q_data_q    <= q_data_d;
        end
    end

    memoria_dados_param #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MEM_LAT(MEM_LAT)
    ) u_mem (
        .Clock  (Clock),
        .Reset  (Reset),
        .wr_en  (mem_wr_en),
        .wr_addr(cur_addr_q),
        .wr_data(cur_data_q),
        .rd_addr(cur_addr_q),
        .rd_data(mem_rd_data)
    );

    assign CDB_req  = (state_q == ST_BCAST);
    assign CDB_tag  = CDB_req ? cur_tag_q : '0;
    assign CDB_data = CDB_req ? result_q : '0;
    assign Busy     = !q_empty || (state_q != ST_IDLE);

endmodule

`default_nettype wire
